// File: rtl/pipe_stage_buffer.sv
// pipe_stage_buffer: registered pipeline-stage buffer carrying control bits,
// a destination address and NDATA payload fields between stages.
// Build option: define PIPE_STAGE_BUFFER_SKID_EN for the two-entry skid buffer
// (registered in_ready); otherwise a single-entry buffer with in_ready
// formed combinationally from the downstream handshake.
module pipe_stage_buffer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NDATA  = 2,
  parameter int unsigned CTRL_W = 3,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CTRL_W-1:0]         in_ctrl,
  input  logic [ADDR_W-1:0]         in_addr,
  input  logic [NDATA*DATA_W-1:0]   in_data,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CTRL_W-1:0]         out_ctrl,
  output logic [ADDR_W-1:0]         out_addr,
  output logic [NDATA*DATA_W-1:0]   out_data,
  output logic [15:0]               stall_cnt
);

  localparam int unsigned PAY_W     = NDATA * DATA_W;
  localparam logic [15:0] STALL_MAX = 16'hFFFF;

  logic              out_valid_q, out_valid_d;
  logic [CTRL_W-1:0] out_ctrl_q,  out_ctrl_d;
  logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
  logic [PAY_W-1:0]  out_data_q,  out_data_d;
  logic [15:0]       stall_q,     stall_d;
  logic              acc, rel;

  assign acc       = in_valid & in_ready;
  assign rel       = out_valid_q & out_ready;
  assign out_valid = out_valid_q;
  assign out_ctrl  = out_ctrl_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign stall_cnt = stall_q;

  // Saturating count of cycles the head waits on downstream; frozen by flush.
  always_comb begin
    stall_d = stall_q;
    if (!flush && out_valid_q && !out_ready && (stall_q != STALL_MAX)) begin
      stall_d = stall_q + 16'd1;
    end
  end

`ifdef PIPE_STAGE_BUFFER_SKID_EN
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;

  state_e            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [ADDR_W-1:0] skid_addr_q, skid_addr_d;
  logic [PAY_W-1:0]  skid_data_q, skid_data_d;

  assign in_ready = in_ready_q;

  // Occupancy FSM: head register feeds the outputs, skid register holds the
  // entry that arrived while the head was stalled.
  always_comb begin
    state_d     = state_q;
    out_ctrl_d  = out_ctrl_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_addr_d = skid_addr_q;
    skid_data_d = skid_data_q;
    unique case (state_q)
      EMPTY: begin
        if (acc) begin
          state_d    = ONE;
          out_ctrl_d = in_ctrl;
          out_addr_d = in_addr;
          out_data_d = in_data;
        end
      end
      ONE: begin
        if (acc && !rel) begin
          state_d     = TWO;
          skid_ctrl_d = in_ctrl;
          skid_addr_d = in_addr;
          skid_data_d = in_data;
        end else if (acc && rel) begin
          out_ctrl_d = in_ctrl;
          out_addr_d = in_addr;
          out_data_d = in_data;
        end else if (rel) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (rel) begin
          state_d    = ONE;
          out_ctrl_d = skid_ctrl_q;
          out_addr_d = skid_addr_q;
          out_data_d = skid_data_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
    end
    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != TWO);
    if (state_d == EMPTY) begin
      out_ctrl_d = '0;
    end
  end

  // Skid-specific state: occupancy, registered ready and the second entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b0;
      skid_ctrl_q <= '0;
      skid_addr_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_addr_q <= skid_addr_d;
      skid_data_q <= skid_data_d;
    end
  end
`else
  logic ready_en_q;

  // Ready whenever the head is free or leaving this cycle; held low in reset.
  assign in_ready = ready_en_q & (~out_valid_q | out_ready);

  // Single head register: a same-cycle accept replaces a departing entry.
  always_comb begin
    out_valid_d = out_valid_q;
    out_ctrl_d  = out_ctrl_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    if (acc) begin
      out_valid_d = 1'b1;
      out_ctrl_d  = in_ctrl;
      out_addr_d  = in_addr;
      out_data_d  = in_data;
    end else if (rel) begin
      out_valid_d = 1'b0;
      out_ctrl_d  = '0;
    end
    if (flush) begin
      out_valid_d = 1'b0;
      out_ctrl_d  = '0;
    end
  end

  // Enables in_ready from the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
    end
  end
`endif

  // Head entry and stall counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_ctrl_q  <= '0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      stall_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_ctrl_q  <= out_ctrl_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      stall_q     <= stall_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Testbench for pipe_stage_buffer: directed steps plus random traffic checked
// against a queue-based reference model of the buffer.
module tb_pipe_stage_buffer;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned NDATA  = 2;
  localparam int unsigned CTRL_W = 3;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned PW     = NDATA * DATA_W;

  typedef struct packed {
    logic [CTRL_W-1:0] c;
    logic [ADDR_W-1:0] a;
    logic [PW-1:0]     d;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [ADDR_W-1:0] in_addr;
  logic [PW-1:0]     in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [ADDR_W-1:0] out_addr;
  logic [PW-1:0]     out_data;
  logic [15:0]       stall_cnt;

  pipe_stage_buffer #(
    .DATA_W(DATA_W), .NDATA(NDATA), .CTRL_W(CTRL_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_addr(in_addr), .in_data(in_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_addr(out_addr), .out_data(out_data), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: FIFO contents, stall count, ready-enable after reset.
  ent_t        mq[$];
  int unsigned mstall;
  bit          men;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_ready(input bit ordy);
`ifdef PIPE_STAGE_BUFFER_SKID_EN
    return men && (mq.size() < 2);
`else
    return men && ((mq.size() == 0) || ordy);
`endif
  endfunction

  task automatic check_out(input string tag);
    check({tag, "_valid"}, 64'(out_valid), 64'(mq.size() > 0));
    check({tag, "_ctrl"}, 64'(out_ctrl), (mq.size() > 0) ? 64'(mq[0].c) : 64'd0);
    if (mq.size() > 0) begin
      check({tag, "_addr"}, 64'(out_addr), 64'(mq[0].a));
      check({tag, "_data"}, 64'(out_data), 64'(mq[0].d));
    end
    check({tag, "_stall"}, 64'(stall_cnt), 64'(mstall));
  endtask

  // One clock: drive inputs, check ready, advance model, check outputs.
  task automatic cycle(input logic vi, input ent_t e, input logic ordy,
                       input logic fl, input bit chk, input string tag);
    bit er, acc, rel, had;
    in_valid  = vi;
    in_ctrl   = e.c;
    in_addr   = e.a;
    in_data   = e.d;
    out_ready = ordy;
    flush     = fl;
    #1;
    er  = model_ready(ordy);
    acc = vi && er;
    had = (mq.size() > 0);
    rel = had && ordy;
    if (chk) check({tag, "_in_ready"}, 64'(in_ready), 64'(er));
    @(posedge clk);
    if (fl) begin
      mq.delete();
    end else begin
      if (rel) void'(mq.pop_front());
      if (acc) mq.push_back(e);
      if (had && !ordy && mstall < 65535) mstall++;
    end
    men = 1'b1;
    @(negedge clk);
    if (chk) check_out(tag);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_rst_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_rst_ctrl"},  64'(out_ctrl),  64'd0);
    check({tag, "_rst_addr"},  64'(out_addr),  64'd0);
    check({tag, "_rst_data"},  64'(out_data),  64'd0);
    check({tag, "_rst_stall"}, 64'(stall_cnt), 64'd0);
    check({tag, "_rst_ready"}, 64'(in_ready),  64'd0);
    mq.delete();
    mstall = 0;
    men    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic ent_t rnd_ent();
    ent_t e;
    e.c = CTRL_W'($urandom);
    e.a = ADDR_W'($urandom);
    e.d = PW'($urandom);
    return e;
  endfunction

  ent_t z;
  ent_t e;

  initial begin
    z = '0;
    rst_n = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_addr = '0; in_data = '0;
    flush = 1'b0; out_ready = 1'b0;
    mq.delete(); mstall = 0; men = 1'b0;

    // Reset, then one idle edge so in_ready rises.
    #2;
    do_reset("init");
    cycle(1'b0, z, 1'b1, 1'b0, 1'b1, "idle");

    // Single transfer with known values.
    e.c = 3'b101; e.a = 4'h7; e.d = 32'h1234ABCD;
    cycle(1'b1, e, 1'b1, 1'b0, 1'b1, "single");
    check("single_const_data", 64'(out_data), 64'h1234ABCD);
    check("single_const_ctrl", 64'(out_ctrl), 64'h5);
    cycle(1'b0, z, 1'b1, 1'b0, 1'b1, "drain");

    // Streaming 8 entries at full rate.
    for (int i = 0; i < 8; i++) begin
      e.c = 3'b001; e.a = ADDR_W'(i); e.d = PW'(i);
      cycle(1'b1, e, 1'b1, 1'b0, 1'b1, "stream");
      check("stream_const_data", 64'(out_data), 64'(i));
    end
    cycle(1'b0, z, 1'b1, 1'b0, 1'b1, "stream_drain");

    // Backpressure: fill under stall, then drain in order.
    for (int i = 0; i < 3; i++) begin
      e.c = 3'b010; e.a = ADDR_W'(8 + i); e.d = PW'(32'hA000 + i);
      cycle(1'b1, e, 1'b0, 1'b0, 1'b1, "bp_fill");
    end
`ifdef PIPE_STAGE_BUFFER_SKID_EN
    check("bp_ready_low", 64'(in_ready), 64'd0);
`endif
    for (int i = 0; i < 3; i++) cycle(1'b0, z, 1'b1, 1'b0, 1'b1, "bp_drain");

    // Flush with the buffer full and a same-cycle input.
    for (int i = 0; i < 2; i++) begin
      e.c = 3'b111; e.a = 4'hE; e.d = PW'(32'hDEAD0000 + i);
      cycle(1'b1, e, 1'b0, 1'b0, 1'b1, "fl_fill");
    end
    e.c = 3'b110; e.a = 4'hD; e.d = 32'hBAD0BAD0;
    cycle(1'b1, e, 1'b0, 1'b1, 1'b1, "flush");
    check("flush_const_valid", 64'(out_valid), 64'd0);
    check("flush_const_ctrl",  64'(out_ctrl),  64'd0);
    for (int i = 0; i < 3; i++) cycle(1'b0, z, 1'b1, 1'b0, 1'b1, "post_flush");

    // Random traffic against the model.
    for (int i = 0; i < 500; i++) begin
      cycle(1'b1 & ($urandom_range(3) != 0), rnd_ent(), ($urandom_range(2) != 0),
            ($urandom_range(24) == 0), 1'b1, "rand");
    end

    // Async reset pulse between edges while entries are held.
    e = rnd_ent();
    cycle(1'b1, e, 1'b0, 1'b0, 1'b1, "pre_rst");
    #2;
    do_reset("mid");
    cycle(1'b0, z, 1'b1, 1'b0, 1'b1, "post_rst");

    // Long stall to saturate stall_cnt.
    e = rnd_ent();
    cycle(1'b1, e, 1'b0, 1'b0, 1'b1, "sat_load");
    for (int i = 0; i < 70000; i++) cycle(1'b0, z, 1'b0, 1'b0, 1'b0, "sat");
    cycle(1'b0, z, 1'b0, 1'b0, 1'b1, "sat_end");
    check("sat_const", 64'(stall_cnt), 64'hFFFF);
    cycle(1'b0, z, 1'b1, 1'b0, 1'b1, "sat_release");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buffer.md
PIPE_STAGE_BUFFER -- requirements
Module: pipe_stage_buffer

Interface
REQ-001 Parameter DATA_W, default 16, width of each data payload field.
REQ-002 Parameter NDATA, default 2, number of data payload fields per entry (1..4).
REQ-003 Parameter CTRL_W, default 3, width of control-bit field (RegWrite, MemOrReg, DestOrPrivate, ...).
REQ-004 Parameter ADDR_W, default 4, width of destination register address.
REQ-005 Port clk  in  1  single clock; all state updates on posedge; the block SHALL have one clock and reset SHALL be asynchronous and active-low.
REQ-006 Port rst_n  in  1  asynchronous active-low reset.
REQ-007 Port in_valid  in  1  upstream entry present.
REQ-008 Port in_ready  out  1  buffer accepts entry this cycle.
REQ-009 Port in_ctrl  in  CTRL_W  control bits.
REQ-010 Port in_addr  in  ADDR_W  destination register address.
REQ-011 Port in_data  in  NDATA*DATA_W  packed payloads, field k at bits [k*DATA_W +: DATA_W].
REQ-012 Port flush  in  1  synchronous kill of all held entries.
REQ-013 Port out_valid  out  1  output entry present.
REQ-014 Port out_ready  in  1  downstream consumes entry.
REQ-015 Ports out_ctrl / out_addr / out_data  out  CTRL_W / ADDR_W / NDATA*DATA_W  registered head entry.
REQ-016 Port stall_cnt  out  16  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-017 Accept occurs on a posedge where in_valid=1 and in_ready=1; release occurs on a posedge where out_valid=1 and out_ready=1.
REQ-018 Latency: an entry accepted at edge N SHALL appear on the outputs, with out_valid=1, after edge N when the buffer was empty.
REQ-019 Outputs SHALL be driven directly from flops, with no combinational path from any input to out_*.
REQ-020 Entries SHALL leave in acceptance order, with no loss or duplication.
REQ-021 While out_valid=1 and out_ready=0, out_ctrl, out_addr and out_data SHALL hold stable.
REQ-022 While out_valid=0, out_ctrl SHALL be all-zero; out_addr and out_data are don't-care.
REQ-023 Flush=1 at an edge SHALL empty the buffer, drop any same-cycle input, force out_valid=0 and out_ctrl=0 after the edge, and leave stall_cnt unchanged.
REQ-024 Flush SHALL take priority over simultaneous accept and release.
REQ-025 stall_cnt SHALL increment by 1 per stalled cycle and saturate at 16'hFFFF.

Reset
REQ-026 rst_n=0 SHALL immediately, without waiting for a clock edge, set the buffer empty, out_valid=0, out_ctrl=0, out_addr=0, out_data=0 and stall_cnt=0.
REQ-027 With rst_n=0, in_ready SHALL be 0.
REQ-028 in_ready SHALL be 1 from the first edge after rst_n deasserts.
REQ-029 An assertion of rst_n mid-transfer SHALL discard all held entries.

Configuration
REQ-030 The macro PIPE_STAGE_BUFFER_SKID_EN SHALL select between two buffer implementations, as defined in REQ-031 and REQ-032.
REQ-031 With PIPE_STAGE_BUFFER_SKID_EN defined: two-entry skid buffer.
- States are EMPTY, ONE and TWO.
- EMPTY->ONE on accept.
- ONE->TWO on accept without release.
- ONE->EMPTY on release without accept.
- ONE stays ONE on simultaneous accept and release.
- TWO->ONE on release; accept is impossible in TWO.
- in_ready SHALL be a flop, equal to 1 exactly when the state is not TWO.
REQ-032 Without PIPE_STAGE_BUFFER_SKID_EN: single-entry buffer.
- in_ready = !out_valid || out_ready, combinational.
- Simultaneous release and accept SHALL replace the head in one cycle.

Verification
REQ-033 Reset, then in_valid=1, in_ctrl=3'b101, in_addr=4'h7, in_data={16'h1234,16'hABCD}, out_ready=1: after 1 edge, out_valid=1 and out_* equal the inputs.
REQ-034 Stream 8 entries (data = i) with out_ready=1 for all cycles: outputs are 0..7 on consecutive cycles and in_ready stays 1.
REQ-035 Backpressure with SKID_EN: with out_ready=0, entries A and B are accepted and in_ready=0 after B; then out_ready=1 yields A then B, and stall_cnt equals the number of stall cycles.
REQ-036 With 2 entries held and flush=1 together with in_valid=1: next cycle out_valid=0, out_ctrl=0, and the flushed and dropped entries never appear.
REQ-037 Async reset mid-stream: rst_n pulsed low between edges sets out_valid=0 and out_data=0 immediately; with out_ready=0 for 70000 cycles, stall_cnt=16'hFFFF.
